// File: rtl/tile_matmul_sequencer_if.sv
`default_nettype none
// tile_matmul_sequencer_if: command, tile-array and status signals of the MATMUL sequencer.
interface tile_matmul_sequencer_if #(
   parameter int NUM_TILES = 24,
   parameter int TIMEOUT_W = 24
);
   logic                 i_cmd_valid;
   logic                 o_cmd_ready;
   logic [NUM_TILES-1:0] i_cmd_tile_en;
   logic [7:0]           i_cmd_left_ugd_len;
   logic [7:0]           i_cmd_right_ugd_len;
   logic [TIMEOUT_W-1:0] i_timeout_cycles;
   logic                 i_abort;
   logic [NUM_TILES-1:0] o_tile_start;
   logic [NUM_TILES-1:0] i_tile_done;
   logic [NUM_TILES-1:0] i_tile_result_valid;
   logic                 o_busy;
   logic                 o_done;
   logic [1:0]           o_err_code;
   logic [NUM_TILES-1:0] o_pending_mask;
   logic [15:0]          o_result_total;
   logic [2:0]           o_state;

   modport slave (
      input  i_cmd_valid, i_cmd_tile_en, i_cmd_left_ugd_len, i_cmd_right_ugd_len,
      input  i_timeout_cycles, i_abort, i_tile_done, i_tile_result_valid,
      output o_cmd_ready, o_tile_start, o_busy, o_done, o_err_code,
      output o_pending_mask, o_result_total, o_state
   );

   modport master (
      output i_cmd_valid, i_cmd_tile_en, i_cmd_left_ugd_len, i_cmd_right_ugd_len,
      output i_timeout_cycles, i_abort, i_tile_done, i_tile_result_valid,
      input  o_cmd_ready, o_tile_start, o_busy, o_done, o_err_code,
      input  o_pending_mask, o_result_total, o_state
   );
endinterface
`default_nettype wire

// File: rtl/tile_matmul_sequencer.sv
`default_nettype none
// tile_matmul_sequencer: launches one MATMUL on the enabled tiles, tracks per-tile done and
// result strobes, and reports completion or an error code to the master control block.
module tile_matmul_sequencer #(
   parameter int NUM_TILES    = 24,
   parameter int TIMEOUT_W    = 24,
   parameter int DRAIN_CYCLES = 4
) (
   input wire logic               i_clk,
   input wire logic               i_reset_n,
   tile_matmul_sequencer_if.slave bus
);
   localparam int CNT_W   = $clog2(NUM_TILES + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic [NUM_TILES-1:0] tile_en, tile_en_nx;
   logic [NUM_TILES-1:0] pending, pending_nx;
   logic [NUM_TILES-1:0] tile_start, tile_start_nx;
   logic [15:0]          expected, expected_nx;
   logic [15:0]          total, total_nx;
   logic [1:0]           err, err_nx;
   logic [TIMEOUT_W-1:0] to_cnt, to_cnt_nx;
   logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nx;

   logic [CNT_W-1:0]     strobes;
   logic [16:0]          sum;
   logic [15:0]          total_acc;
   logic [NUM_TILES-1:0] pend_cleared;
   logic                 to_last;

   always_comb begin
      strobes = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         strobes = strobes + CNT_W'(bus.i_tile_result_valid[i]);
      end
      sum          = {1'b0, total} + 17'(strobes);
      total_acc    = sum[16] ? 16'hFFFF : sum[15:0];
      pend_cleared = pending & ~bus.i_tile_done;
      to_last      = (bus.i_timeout_cycles != '0) &&
                     (to_cnt == bus.i_timeout_cycles - TIMEOUT_W'(1));
   end

   always_comb begin
      state_nx      = state;
      tile_en_nx    = tile_en;
      pending_nx    = pending;
      tile_start_nx = '0;
      expected_nx   = expected;
      total_nx      = total;
      err_nx        = err;
      to_cnt_nx     = to_cnt;
      drain_cnt_nx  = drain_cnt;

      // Abort outranks every other transition and leaves status registers untouched.
      if (state != S_IDLE && bus.i_abort) begin
         state_nx   = S_IDLE;
         pending_nx = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.i_cmd_valid && !bus.i_abort) begin
                  tile_en_nx  = bus.i_cmd_tile_en;
                  expected_nx = 16'(bus.i_cmd_left_ugd_len) * 16'(bus.i_cmd_right_ugd_len);
                  total_nx    = '0;
                  err_nx      = 2'd0;
                  if (bus.i_cmd_tile_en == '0) begin
                     state_nx = S_DONE;
                     err_nx   = 2'd3;
                  end else begin
                     state_nx      = S_START;
                     tile_start_nx = bus.i_cmd_tile_en;
                  end
               end
            end
            S_START: begin
               total_nx   = total_acc;
               pending_nx = tile_en;
               to_cnt_nx  = '0;
               state_nx   = S_WAIT;
            end
            S_WAIT: begin
               total_nx   = total_acc;
               pending_nx = pend_cleared;
               to_cnt_nx  = to_cnt + TIMEOUT_W'(1);
               // A final done arriving with the timeout still completes normally.
               if (pend_cleared == '0) begin
                  state_nx     = S_DRAIN;
                  drain_cnt_nx = '0;
               end else if (to_last) begin
                  state_nx = S_DONE;
                  err_nx   = 2'd1;
               end
            end
            S_DRAIN: begin
               total_nx     = total_acc;
               drain_cnt_nx = drain_cnt + DRAIN_W'(1);
               if (total_acc > expected) begin
                  state_nx = S_DONE;
                  err_nx   = 2'd2;
               end else if (total_acc == expected) begin
                  state_nx = S_DONE;
                  err_nx   = 2'd0;
               end else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                  state_nx = S_DONE;
                  err_nx   = 2'd2;
               end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tile_en    <= '0;
         pending    <= '0;
         tile_start <= '0;
         expected   <= '0;
         total      <= '0;
         err        <= '0;
         to_cnt     <= '0;
         drain_cnt  <= '0;
      end else begin
         tile_en    <= tile_en_nx;
         pending    <= pending_nx;
         tile_start <= tile_start_nx;
         expected   <= expected_nx;
         total      <= total_nx;
         err        <= err_nx;
         to_cnt     <= to_cnt_nx;
         drain_cnt  <= drain_cnt_nx;
      end
   end

   assign bus.o_cmd_ready    = (state == S_IDLE);
   assign bus.o_busy         = (state != S_IDLE);
   assign bus.o_done         = (state == S_DONE);
   assign bus.o_tile_start   = tile_start;
   assign bus.o_err_code     = err;
   assign bus.o_pending_mask = pending;
   assign bus.o_result_total = total;
   assign bus.o_state        = state;
endmodule
`default_nettype wire

// File: tb/tb_tile_matmul_sequencer.sv
`default_nettype none
// tb_tile_matmul_sequencer: directed and randomized commands checked against a
// schedule-level reference model of the sequencer's completion rules.
module tb_tile_matmul_sequencer;
   localparam int NT    = 24;
   localparam int TW    = 24;
   localparam int DR    = 4;
   localparam int SZ    = 3000;
   localparam int NEVER = 1000000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vectors     = 0;
   int   n_miscompares = 0;

   // Per-cycle stimulus, indexed by cycles since the command was presented (0 = accept cycle).
   logic [NT-1:0] done_s   [SZ];
   logic [NT-1:0] strobe_s [SZ];

   tile_matmul_sequencer_if #(.NUM_TILES(NT), .TIMEOUT_W(TW)) bus ();

   tile_matmul_sequencer #(
      .NUM_TILES   (NT),
      .TIMEOUT_W   (TW),
      .DRAIN_CYCLES(DR)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vectors++;
      if (got !== want) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.i_cmd_valid         = 1'b0;
      bus.i_cmd_tile_en       = '0;
      bus.i_cmd_left_ugd_len  = '0;
      bus.i_cmd_right_ugd_len = '0;
      bus.i_timeout_cycles    = '0;
      bus.i_abort             = 1'b0;
      bus.i_tile_done         = '0;
      bus.i_tile_result_valid = '0;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < SZ; i++) begin
         done_s[i]   = '0;
         strobe_s[i] = '0;
      end
   endtask

   // Results counted from the START cycle (1) through cycle upto, saturating at 16 bits.
   function automatic int ssum(input int upto);
      int s = 0;
      for (int k = 1; k <= upto && k < SZ; k++) s += $countones(strobe_s[k]);
      return (s > 65535) ? 65535 : s;
   endfunction

   task automatic model(input logic [NT-1:0] en, input int expv, input int tmo,
                        output int cyc, output int err, output int tot,
                        output logic [NT-1:0] pend);
      int first_done [NT];
      int last;
      int s;
      cyc = 0; err = 0; tot = 0; pend = '0;
      if (en == '0) begin
         cyc = 1; err = 3;
         return;
      end
      last = 0;
      for (int t = 0; t < NT; t++) begin
         first_done[t] = NEVER;
         if (en[t]) begin
            for (int k = 2; k < SZ; k++) begin
               if (done_s[k][t]) begin
                  first_done[t] = k;
                  break;
               end
            end
            if (first_done[t] > last) last = first_done[t];
         end
      end
      // WAIT spans cycles 2..tmo+1; a done in that last cycle still wins.
      if (tmo != 0 && last > tmo + 1) begin
         cyc = tmo + 2; err = 1; tot = ssum(tmo + 1);
         for (int t = 0; t < NT; t++) if (en[t] && first_done[t] > tmo + 1) pend[t] = 1'b1;
         return;
      end
      for (int k = last + 1; k <= last + DR; k++) begin
         s = ssum(k);
         if (s >= expv) begin
            cyc = k + 1; err = (s == expv) ? 0 : 2; tot = s;
            return;
         end
      end
      cyc = last + DR + 1; err = 2; tot = ssum(last + DR);
   endtask

   // abort_req: 0 none, -1 random point before completion, >0 that cycle.
   task automatic run_cmd(input logic [NT-1:0] en, input int b, input int c,
                          input int tmo, input int abort_req);
      int ecyc, eerr, etot, abort_at, done_at, budget;
      logic [NT-1:0] epend;
      logic ts_ok;
      model(en, b * c, tmo, ecyc, eerr, etot, epend);
      abort_at = (abort_req > 0) ? abort_req : 0;
      if (abort_req < 0 && ecyc >= 2) abort_at = $urandom_range(1, ecyc - 1);
      budget = (abort_at > 0) ? abort_at + 6 : ecyc + 8;

      bus.i_cmd_valid         = 1'b1;
      bus.i_cmd_tile_en       = en;
      bus.i_cmd_left_ugd_len  = 8'(b);
      bus.i_cmd_right_ugd_len = 8'(c);
      bus.i_timeout_cycles    = TW'(tmo);
      bus.i_abort             = 1'b0;
      bus.i_tile_done         = done_s[0];
      bus.i_tile_result_valid = strobe_s[0];
      done_at = -1;
      ts_ok   = 1'b1;

      for (int cyc = 1; cyc <= budget; cyc++) begin
         tick();
         if (cyc == 1) begin
            check_value("tile_start", bus.o_tile_start, en);
            check_value("busy", bus.o_busy, 1);
         end else if (bus.o_tile_start != '0) begin
            ts_ok = 1'b0;
         end
         if (abort_at > 0 && cyc == abort_at + 1) begin
            check_value("abort_busy", bus.o_busy, 0);
            check_value("abort_pending", bus.o_pending_mask, 0);
            check_value("abort_total", bus.o_result_total, ssum(abort_at - 1));
            check_value("abort_err", bus.o_err_code, 0);
         end
         if (bus.o_done === 1'b1 && done_at < 0) begin
            done_at = cyc;
            if (abort_at == 0) begin
               check_value("err_code", bus.o_err_code, eerr);
               check_value("result_total", bus.o_result_total, etot);
               if (en != '0) check_value("pending", bus.o_pending_mask, epend);
               break;
            end
         end
         bus.i_cmd_valid         = (abort_at == 0 || cyc < abort_at) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.i_cmd_tile_en       = NT'($urandom);
         bus.i_cmd_left_ugd_len  = 8'($urandom);
         bus.i_cmd_right_ugd_len = 8'($urandom);
         bus.i_abort             = (cyc == abort_at);
         bus.i_tile_done         = done_s[cyc];
         bus.i_tile_result_valid = strobe_s[cyc];
      end

      check_value("tile_start_once", ts_ok, 1);
      if (abort_at > 0) begin
         check_value("abort_no_done", done_at, -1);
         check_value("abort_hold", bus.o_result_total, ssum(abort_at - 1));
      end else begin
         check_value("done_cycle", done_at, ecyc);
         drive_idle();
         bus.i_tile_result_valid = NT'($urandom);
         tick();
         check_value("ready_after", bus.o_cmd_ready, 1);
         check_value("total_hold", bus.o_result_total, etot);
         check_value("err_hold", bus.o_err_code, eerr);
      end
      drive_idle();
      tick();
   endtask

   task automatic gen_random(output logic [NT-1:0] en, output int b, output int c, output int tmo);
      int last, never_t, mode, n, hi, cy, t, d;
      clear_sched();
      en = NT'($urandom);
      if ($urandom_range(0, 2) == 0) en = NT'(1) << $urandom_range(0, NT - 1);
      if (en == '0) en = NT'(1);
      tmo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      never_t = -1;
      if (tmo != 0 && $urandom_range(0, 1) == 1) begin
         t = $urandom_range(0, NT - 1);
         for (int i = 0; i < NT; i++) if (never_t < 0 && en[(t + i) % NT]) never_t = (t + i) % NT;
      end
      last = 2;
      for (int i = 0; i < NT; i++) begin
         if (en[i] && i != never_t) begin
            d = $urandom_range(2, 25);
            done_s[d][i] = 1'b1;
            if (d > last) last = d;
         end
      end
      done_s[1] = NT'($urandom);
      for (int k = 2; k < 40; k++) done_s[k] = done_s[k] | (NT'($urandom) & ~en);
      b    = $urandom_range(1, 6);
      c    = $urandom_range(1, 8);
      mode = $urandom_range(0, 3);
      case (mode)
         0, 1:    n = b * c;
         2:       n = $urandom_range(0, b * c - 1);
         default: n = b * c + $urandom_range(1, 3);
      endcase
      hi = (mode == 0) ? last : last + DR;
      for (int i = 0; i < n; i++) begin
         for (int tries = 0; tries < 1000; tries++) begin
            cy = $urandom_range(1, hi);
            t  = $urandom_range(0, NT - 1);
            if (!strobe_s[cy][t]) begin
               strobe_s[cy][t] = 1'b1;
               break;
            end
         end
      end
      strobe_s[0] = NT'($urandom);
   endtask

   initial begin
      logic [NT-1:0] en;
      int b, c, tmo;
      drive_idle();
      clear_sched();
      repeat (3) tick();
      check_value("rst_ready", bus.o_cmd_ready, 1);
      check_value("rst_busy", bus.o_busy, 0);
      check_value("rst_done", bus.o_done, 0);
      check_value("rst_err", bus.o_err_code, 0);
      check_value("rst_pending", bus.o_pending_mask, 0);
      check_value("rst_total", bus.o_result_total, 0);
      check_value("rst_start", bus.o_tile_start, 0);
      rst_n = 1'b1;
      tick();

      // Four tiles, all 16 results before the last done.
      clear_sched();
      done_s[10][0] = 1'b1; done_s[12][1] = 1'b1; done_s[14][2] = 1'b1; done_s[16][3] = 1'b1;
      for (int k = 2; k <= 9; k++) strobe_s[k] = NT'(3);
      run_cmd(NT'(24'h00000F), 2, 8, 0, 0);

      // Last two results land two cycles into the drain window.
      clear_sched();
      done_s[10][0] = 1'b1; done_s[12][1] = 1'b1; done_s[14][2] = 1'b1; done_s[16][3] = 1'b1;
      for (int k = 2; k <= 8; k++) strobe_s[k] = NT'(3);
      strobe_s[18] = NT'(3);
      run_cmd(NT'(24'h00000F), 2, 8, 0, 0);

      // Short on results: drain window expires.
      clear_sched();
      done_s[5][0] = 1'b1; done_s[8][1] = 1'b1;
      strobe_s[3] = NT'(1); strobe_s[4] = NT'(1); strobe_s[6] = NT'(1);
      run_cmd(NT'(24'h000003), 1, 4, 0, 0);

      // Tile 1 never finishes.
      clear_sched();
      done_s[5][0] = 1'b1;
      strobe_s[3] = NT'(1);
      run_cmd(NT'(24'h000003), 1, 4, 20, 0);

      // Empty tile mask.
      clear_sched();
      run_cmd(NT'(0), 3, 3, 0, 0);

      // Abort mid-WAIT, then a clean command.
      clear_sched();
      done_s[10][0] = 1'b1; done_s[11][1] = 1'b1;
      strobe_s[2] = NT'(1); strobe_s[3] = NT'(2);
      run_cmd(NT'(24'h000003), 2, 2, 0, 6);
      clear_sched();
      done_s[4][0] = 1'b1; done_s[7][2] = 1'b1;
      strobe_s[2] = NT'(1); strobe_s[5] = NT'(4); strobe_s[7] = NT'(1);
      run_cmd(NT'(24'h000005), 1, 3, 0, 0);

      // Abort together with a command in IDLE blocks the accept.
      bus.i_cmd_valid   = 1'b1;
      bus.i_cmd_tile_en = NT'(3);
      bus.i_abort       = 1'b1;
      tick();
      check_value("abort_idle_block", bus.o_busy, 0);
      drive_idle();
      tick();

      for (int r = 0; r < 40; r++) begin
         gen_random(en, b, c, tmo);
         run_cmd(en, b, c, tmo, (r % 5 == 4) ? -1 : 0);
      end

      // Result counter saturation, then an over-count in DRAIN.
      clear_sched();
      done_s[2760][0] = 1'b1;
      for (int k = 1; k <= 2760; k++) strobe_s[k] = '1;
      run_cmd(NT'(1), 255, 255, 0, 0);

      // Asynchronous reset in the middle of WAIT.
      clear_sched();
      bus.i_cmd_valid         = 1'b1;
      bus.i_cmd_tile_en       = NT'(24'h0000FF);
      bus.i_cmd_left_ugd_len  = 8'd4;
      bus.i_cmd_right_ugd_len = 8'd4;
      tick();
      bus.i_cmd_valid         = 1'b0;
      bus.i_tile_result_valid = NT'(24'h00000F);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_value("arst_busy", bus.o_busy, 0);
      check_value("arst_ready", bus.o_cmd_ready, 1);
      check_value("arst_total", bus.o_result_total, 0);
      check_value("arst_pending", bus.o_pending_mask, 0);
      check_value("arst_start", bus.o_tile_start, 0);
      drive_idle();
      #2;
      rst_n = 1'b1;
      tick();
      check_value("arst_idle", bus.o_cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
`default_nettype wire
